ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin AHB bus arbiter that sits directly upstream of the slave-to-master response mux. It grants the shared bus to one of `NUM_MASTERS` requesters and produces the address-phase owner index `Hmaster`, which the response mux registers to route read data and responses back. It also produces the lock indication `Hmastlock`. Grants are held for the full length of fixed-length bursts and for locked sequences.

## Interface
- `NUM_MASTERS`, default 2: number of requesting masters, at least 1.
- `MASTER_WIDTH`, default `(NUM_MASTERS>1) ? $clog2(NUM_MASTERS) : 1`: width of `Hmaster`.
- `DEFAULT_MASTER`, default 0: index granted at reset and whenever no master requests.

Ports (one clock; reset is asynchronous and active-low):
- `Hclk` input 1: bus clock, rising edge.
- `Hresetn` input 1: asynchronous active-low reset.
- `Hbusreq` input `[NUM_MASTERS-1:0]`: per-master bus request.
- `Hlock` input `[NUM_MASTERS-1:0]`: per-master locked-access request.
- `Htrans` input 2: transfer type of the current address-phase owner. 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hburst` input 3: burst type of the current owner.
- `Hready` input 1: global ready from the slave-to-master mux.
- `Hgrant` output `[NUM_MASTERS-1:0]`: one-hot grant, always exactly one bit set.
- `Hmaster` output `MASTER_WIDTH`: address-phase owner index.
- `Hmastlock` output 1: current owner is performing a locked sequence.

## Operation
- Reset state:
  - `Hgrant` is one-hot at `DEFAULT_MASTER`.
  - `Hmaster` = `DEFAULT_MASTER`.
  - `Hmastlock` = 0.
  - State = ARB.
  - Round-robin pointer = `DEFAULT_MASTER`.
  - Beat counter = 0.
- States: ARB, BURST, LOCK.
- ARB arbitration rule:
  - Search `Hbusreq` starting at index (`Hmaster`+1) mod `NUM_MASTERS` and wrapping; the first set bit wins.
  - The current owner is re-granted only if no other master requests.
  - If no master requests, grant `DEFAULT_MASTER`.
- ARB → LOCK: `Hlock[Hmaster]` and `Hbusreq[Hmaster]` are both 1. The grant is frozen on `Hmaster`.
- LOCK → ARB: `Hlock[Hmaster]`=0. Arbitration resumes in the same cycle.
- ARB → BURST, taken from ARB or LOCK-free operation: the owner issues NONSEQ with `Hready`=1 and `Hburst` in {WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} (encodings 2..7).
  - The counter loads 3, 7 or 15 for 4, 8 or 16 beats respectively.
  - The grant is frozen.
- In BURST:
  - SEQ with `Hready`=1 decrements the counter.
  - BUSY, or `Hready`=0, holds the counter.
  - SEQ accepted with counter==1 → counter 0, go to ARB.
- Early termination: the owner issues IDLE or NONSEQ with `Hready`=1 while in BURST.
  - Go to ARB.
  - A NONSEQ fixed burst instead reloads the counter and stays in BURST.
- SINGLE (0) and INCR (1) never enter BURST. INCR ownership relies on round-robin only.
- Lock has priority over burst: if `Hlock[Hmaster]`=1 during ARB evaluation, LOCK is entered even while burst counting is pending.
- `Hmaster`/`Hmastlock` update rule: at a rising edge with `Hready`=1, `Hmaster` ← index of `Hgrant` and `Hmastlock` ← `Hlock[that index]`. Both hold otherwise.
- Round-robin pointer = `Hmaster` (the last address owner).
- Reset assertion mid-burst or mid-lock returns all outputs to reset values immediately (asynchronously). No burst state survives.

## Timing
- `Hgrant` is registered. An arbitration decision made in cycle N, evaluated only when `Hready`=1, appears on `Hgrant` after edge N.
- While `Hready`=0, `Hgrant`, `Hmaster` and `Hmastlock` all hold.
- Handover latency:
  - Request to `Hgrant`: 1 cycle.
  - `Hgrant` to `Hmaster`: the next edge with `Hready`=1.
  - Minimum is 2 edges from request to `Hmaster` change.
- End of fixed burst: the grant can move at the edge after the last SEQ is accepted. `Hmaster` moves one `Hready` edge later.
- `Hgrant` is never zero or multi-hot, including with `NUM_MASTERS`=1. In that case `Hgrant` is 1 and `Hmaster` is 0 permanently.

## Test plan
- Reset with `Hbusreq`=0 → `Hgrant`=01, `Hmaster`=0, `Hmastlock`=0. The outputs stay there for 10 cycles.
- `Hbusreq`=10, `Hready`=1 → `Hgrant`=10 after 1 edge and `Hmaster`=1 after 2 edges. Then drop `Hbusreq` → `Hgrant` returns to 01.
- `Hbusreq`=11 held, single transfers, `Hready`=1 → `Hmaster` alternates 0,1,0,1.
- Master 0 NONSEQ INCR4 plus 3 SEQ, with `Hbusreq`=11 and one `Hready`=0 wait in beat 2 → `Hgrant` stays 01 through the burst. It moves to 10 only after the 4th beat is accepted, and the wait cycle does not decrement the count.
- Master 1 `Hlock`=1 with `Hbusreq`=11 for 6 transfers → `Hgrant`=10 and `Hmastlock`=1 throughout. After `Hlock`=0, the grant moves to 01 and `Hmastlock` clears at the next `Hready` edge.
- `Hresetn` pulsed low mid-INCR8 of master 1 → outputs return to `Hgrant`=01, `Hmaster`=0 without waiting for a clock. After release, arbitration starts fresh in ARB.

Source files
------------

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter.
// Produces a registered one-hot grant plus the address-phase owner (Hmaster)
// and lock indication (Hmastlock). The grant is held across fixed-length
// bursts and locked sequences; otherwise ownership rotates starting after the
// last address-phase owner.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int MASTER_WIDTH   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic [NUM_MASTERS-1:0]  Hbusreq,
  input  logic [NUM_MASTERS-1:0]  Hlock,
  input  logic [1:0]              Htrans,
  input  logic [2:0]              Hburst,
  input  logic                    Hready,
  output logic [NUM_MASTERS-1:0]  Hgrant,
  output logic [MASTER_WIDTH-1:0] Hmaster,
  output logic                    Hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [MASTER_WIDTH-1:0] DEF_IDX = MASTER_WIDTH'(DEFAULT_MASTER);

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_e;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MASTER_WIDTH-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [MASTER_WIDTH-1:0] master_q, master_d;
  logic                    mastlock_q, mastlock_d;

  logic [MASTER_WIDTH-1:0] grant_idx;
  logic [MASTER_WIDTH-1:0] rr_idx;
  logic                    owner_lock;
  logic                    fixed_burst;
  logic [3:0]              burst_len;
  logic [NUM_MASTERS-1:0]  own_oh;

  // Index of the currently granted master (grant is always one-hot).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) grant_idx = MASTER_WIDTH'(i);
  end

  // Round-robin search starting just after the last address owner; the
  // owner itself is checked last so it only keeps the bus when alone.
  always_comb begin : rr_search
    logic found;
    int   j;
    found  = 1'b0;
    j      = 0;
    rr_idx = DEF_IDX;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      j = (int'(master_q) + off) % NUM_MASTERS;
      if (!found && Hbusreq[j]) begin
        found  = 1'b1;
        rr_idx = MASTER_WIDTH'(j);
      end
    end
  end

  // Burst decode: fixed-length bursts load beats-1 into the counter.
  always_comb begin
    fixed_burst = (Hburst >= 3'd2);
    case (Hburst[2:1])
      2'b01:   burst_len = 4'd3;
      2'b10:   burst_len = 4'd7;
      2'b11:   burst_len = 4'd15;
      default: burst_len = 4'd0;
    endcase
  end

  assign owner_lock = Hlock[master_q] & Hbusreq[master_q];
  assign own_oh     = onehot(master_q);

  // Next-state: everything is evaluated only on Hready cycles and held otherwise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (Hready) begin
      master_d   = grant_idx;
      mastlock_d = Hlock[grant_idx];
      case (state_q)
        ARB: begin
          if (owner_lock) begin
            state_d = LOCK;
            cnt_d   = 4'd0;
            grant_d = own_oh;
          end else if (Htrans == TR_NONSEQ && fixed_burst) begin
            state_d = BURST;
            cnt_d   = burst_len;
            grant_d = own_oh;
          end else begin
            grant_d = onehot(rr_idx);
          end
        end
        BURST: begin
          // A lock request from the owner pre-empts the remaining beats.
          if (owner_lock) begin
            state_d = LOCK;
            cnt_d   = 4'd0;
            grant_d = own_oh;
          end else begin
            case (Htrans)
              TR_SEQ: begin
                if (cnt_q <= 4'd1) begin
                  cnt_d   = 4'd0;
                  state_d = ARB;
                end else begin
                  cnt_d = cnt_q - 4'd1;
                end
              end
              TR_NONSEQ: begin
                if (fixed_burst) begin
                  cnt_d = burst_len;
                end else begin
                  cnt_d   = 4'd0;
                  state_d = ARB;
                end
              end
              TR_IDLE: begin
                cnt_d   = 4'd0;
                state_d = ARB;
              end
              default: ; // BUSY holds the count
            endcase
          end
        end
        LOCK: begin
          // Unlock re-arbitrates in the same cycle rather than idling.
          if (!Hlock[master_q]) begin
            state_d = ARB;
            grant_d = onehot(rr_idx);
          end
        end
        default: begin
          state_d = ARB;
          cnt_d   = 4'd0;
          grant_d = onehot(DEF_IDX);
        end
      endcase
    end
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q    <= ARB;
      cnt_q      <= 4'd0;
      grant_q    <= onehot(DEF_IDX);
      master_q   <= DEF_IDX;
      mastlock_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = master_q;
  assign Hmastlock = mastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a vector table covering handover,
// alternation, a fixed burst with a wait state and a locked sequence, then
// a hand-written asynchronous reset in the middle of a burst.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;

  logic       Hclk = 1'b0;
  logic       Hresetn;
  logic [1:0] Hbusreq, Hlock, Htrans;
  logic [2:0] Hburst;
  logic       Hready;
  logic [1:0] Hgrant;
  logic [0:0] Hmaster;
  logic       Hmastlock;
  logic [0:0] g1, m1;
  logic       ml1;

  int errors = 0;
  int checks = 0;

  always #5 Hclk = ~Hclk;

  ahb_arbiter #(.NUM_MASTERS(2)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq), .Hlock(Hlock),
    .Htrans(Htrans), .Hburst(Hburst), .Hready(Hready),
    .Hgrant(Hgrant), .Hmaster(Hmaster), .Hmastlock(Hmastlock)
  );

  // Single-master instance: grant must be permanently 1, owner 0.
  ahb_arbiter #(.NUM_MASTERS(1)) dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hbusreq(Hbusreq[0:0]), .Hlock(Hlock[0:0]),
    .Htrans(Htrans), .Hburst(Hburst), .Hready(Hready),
    .Hgrant(g1), .Hmaster(m1), .Hmastlock(ml1)
  );

  typedef struct {
    logic [1:0] req, lk, tr;
    logic [2:0] bu;
    logic       rdy;
    logic [1:0] g;
    logic       m, ml;
    string      nm;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [1:0] req, lk, tr, input logic [2:0] bu,
                              input logic rdy, input logic [1:0] g, input logic m, ml,
                              input string nm);
    vec_t x;
    x.req = req; x.lk = lk; x.tr = tr; x.bu = bu; x.rdy = rdy;
    x.g = g; x.m = m; x.ml = ml; x.nm = nm;
    vt.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, lk, tr, input logic [2:0] bu, input logic rdy);
    Hbusreq = req; Hlock = lk; Htrans = tr; Hburst = bu; Hready = rdy;
  endtask

  initial begin
    // Handover of master 1 and return to default.
    add(2'b10, 2'b00, IDLE, 3'd0, 1'b1, 2'b10, 1'b0, 1'b0, "req1_grant");
    add(2'b10, 2'b00, IDLE, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, "req1_master");
    add(2'b00, 2'b00, IDLE, 3'd0, 1'b1, 2'b01, 1'b1, 1'b0, "drop_grant");
    add(2'b00, 2'b00, IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, "drop_master");
    // Both requesting, single transfers: ownership alternates.
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b10, 1'b0, 1'b0, "alt_a");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b0, "alt_b");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b01, 1'b1, 1'b0, "alt_c");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b01, 1'b0, 1'b0, "alt_d");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b10, 1'b0, 1'b0, "alt_e");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b0, "alt_f");
    add(2'b00, 2'b00, IDLE, 3'd0, 1'b1, 2'b01, 1'b1, 1'b0, "park_a");
    add(2'b00, 2'b00, IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, "park_b");
    // Master 0 INCR4 with a wait state on beat 2; grant frozen throughout.
    add(2'b11, 2'b00, NS,   3'd3, 1'b1, 2'b01, 1'b0, 1'b0, "incr4_ns");
    add(2'b11, 2'b00, SEQ,  3'd3, 1'b1, 2'b01, 1'b0, 1'b0, "incr4_seq1");
    add(2'b11, 2'b00, SEQ,  3'd3, 1'b0, 2'b01, 1'b0, 1'b0, "incr4_wait");
    add(2'b11, 2'b00, SEQ,  3'd3, 1'b1, 2'b01, 1'b0, 1'b0, "incr4_seq2");
    add(2'b11, 2'b00, SEQ,  3'd3, 1'b1, 2'b01, 1'b0, 1'b0, "incr4_seq3");
    add(2'b11, 2'b00, IDLE, 3'd0, 1'b1, 2'b10, 1'b0, 1'b0, "incr4_release");
    // Master 1 locked for six transfers, then unlock.
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_1");
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_2");
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_3");
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_4");
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_5");
    add(2'b11, 2'b10, NS,   3'd0, 1'b1, 2'b10, 1'b1, 1'b1, "lock_6");
    add(2'b11, 2'b00, NS,   3'd0, 1'b1, 2'b01, 1'b1, 1'b0, "unlock");
    add(2'b11, 2'b00, IDLE, 3'd0, 1'b1, 2'b01, 1'b0, 1'b0, "unlock_master");
    // Hready low holds a pending grant change.
    add(2'b10, 2'b00, IDLE, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, "rdy0_hold");
    add(2'b10, 2'b00, IDLE, 3'd0, 1'b1, 2'b10, 1'b0, 1'b0, "rdy1_grant");
    add(2'b10, 2'b00, IDLE, 3'd0, 1'b1, 2'b10, 1'b1, 1'b0, "rdy1_master");

    Hresetn = 1'b0;
    drive(2'b00, 2'b00, IDLE, 3'd0, 1'b1);
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;
    #1;
    chk("rst_grant", 32'(Hgrant), 32'h1);
    chk("rst_master", 32'(Hmaster), 32'h0);
    chk("rst_mastlock", 32'(Hmastlock), 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(posedge Hclk); #1;
      chk("idle_grant", 32'(Hgrant), 32'h1);
      chk("idle_master", 32'(Hmaster), 32'h0);
      chk("idle_mastlock", 32'(Hmastlock), 32'h0);
    end

    foreach (vt[i]) begin
      @(negedge Hclk);
      drive(vt[i].req, vt[i].lk, vt[i].tr, vt[i].bu, vt[i].rdy);
      @(posedge Hclk); #1;
      chk({vt[i].nm, "_grant"}, 32'(Hgrant), 32'(vt[i].g));
      chk({vt[i].nm, "_master"}, 32'(Hmaster), 32'(vt[i].m));
      chk({vt[i].nm, "_mastlock"}, 32'(Hmastlock), 32'(vt[i].ml));
      chk({vt[i].nm, "_n1"}, {30'd0, g1, m1}, 32'h2);
    end

    // Master 1 starts INCR8, reset is pulsed between clock edges.
    @(negedge Hclk);
    drive(2'b10, 2'b00, NS, 3'd5, 1'b1);
    @(posedge Hclk); #1;
    chk("incr8_grant", 32'(Hgrant), 32'h2);
    chk("incr8_master", 32'(Hmaster), 32'h1);
    @(negedge Hclk);
    drive(2'b11, 2'b00, SEQ, 3'd5, 1'b1);
    repeat (2) @(posedge Hclk);
    #1;
    chk("incr8_frozen", 32'(Hgrant), 32'h2);
    @(negedge Hclk);
    #2 Hresetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(Hgrant), 32'h1);
    chk("async_rst_master", 32'(Hmaster), 32'h0);
    chk("async_rst_mastlock", 32'(Hmastlock), 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    drive(2'b10, 2'b00, IDLE, 3'd0, 1'b1);
    @(posedge Hclk); #1;
    chk("fresh_arb_grant", 32'(Hgrant), 32'h2);
    chk("fresh_arb_master", 32'(Hmaster), 32'h0);
    @(posedge Hclk); #1;
    chk("fresh_arb_master2", 32'(Hmaster), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
